spinnaker_fpgas_reg_arbiter: RTL and testbench

SPINNAKER_FPGAS_REG_ARBITER -- requirements
Module: spinnaker_fpgas_reg_arbiter

---
 rtl/spinnaker_fpgas_reg_arbiter.sv | 158 +++++++++++++++
 tb/tb_spinnaker_fpgas_reg_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spinnaker_fpgas_reg_arbiter.sv
// spinnaker_fpgas_reg_arbiter
//
// Two-requester round-robin arbiter in front of a single-ported register
// bank. Requester 0 is the host SPI link and requester 1 is local
// diagnostics. Only one access is in flight at a time, and no requests are
// buffered. Each access walks through three states:
//   IDLE  -> accept one request (round-robin)
//   ISSUE -> drive the bank for one cycle and capture its read data
//   RESP  -> hold the response for the owner until it is taken or times out
//
// Ports
//   CLK_IN, RESET_N_IN           : clock and asynchronous active-low reset
//   REQn_VLD_IN/REQn_RDY_OUT     : request handshake, n = 0,1
//   REQn_WRITE_IN/ADDR_IN/DATA_IN: request fields
//   RSPn_VLD_OUT/RSPn_RDY_IN     : response handshake
//   RSPn_DATA_OUT                : read data; for a write, the pre-write value
//   BANK_*                       : register bank strobe, address, data
//   TIMEOUT_OUT                  : one-cycle pulse when a response is dropped
module spinnaker_fpgas_reg_arbiter #(
  parameter int REGA_BITS    = 14,
  parameter int REGD_BITS    = 32,
  parameter int TIMEOUT_BITS = 8
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_N_IN,
  input  logic                 REQ0_VLD_IN,
  output logic                 REQ0_RDY_OUT,
  input  logic                 REQ0_WRITE_IN,
  input  logic [REGA_BITS-1:0] REQ0_ADDR_IN,
  input  logic [REGD_BITS-1:0] REQ0_DATA_IN,
  input  logic                 REQ1_VLD_IN,
  output logic                 REQ1_RDY_OUT,
  input  logic                 REQ1_WRITE_IN,
  input  logic [REGA_BITS-1:0] REQ1_ADDR_IN,
  input  logic [REGD_BITS-1:0] REQ1_DATA_IN,
  output logic                 RSP0_VLD_OUT,
  input  logic                 RSP0_RDY_IN,
  output logic [REGD_BITS-1:0] RSP0_DATA_OUT,
  output logic                 RSP1_VLD_OUT,
  input  logic                 RSP1_RDY_IN,
  output logic [REGD_BITS-1:0] RSP1_DATA_OUT,
  output logic                 BANK_WRITE_OUT,
  output logic [REGA_BITS-1:0] BANK_ADDR_OUT,
  output logic [REGD_BITS-1:0] BANK_WRITE_DATA_OUT,
  input  logic [REGD_BITS-1:0] BANK_READ_DATA_IN,
  output logic                 TIMEOUT_OUT
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    owner_q, owner_d;
  logic                    write_q, write_d;
  logic [REGA_BITS-1:0]    addr_q, addr_d;
  logic [REGD_BITS-1:0]    data_q, data_d;
  logic [REGD_BITS-1:0]    rsp_data_q, rsp_data_d;
  logic [TIMEOUT_BITS-1:0] timer_q, timer_d;

  logic grant;
  logic accept;
  logic rsp_rdy;
  logic timer_max;

  // Round-robin winner: with both requesters valid, the one not served last
  // wins; otherwise whichever is valid. RDY is gated by reset so that no
  // handshake is offered while the block is held in reset.
  always_comb begin
    grant = REQ1_VLD_IN;
    if (REQ0_VLD_IN && REQ1_VLD_IN) begin
      grant = ~last_q;
    end
    accept       = (state_q == IDLE) && (REQ0_VLD_IN || REQ1_VLD_IN) && RESET_N_IN;
    REQ0_RDY_OUT = accept && !grant;
    REQ1_RDY_OUT = accept && grant;
  end

  // Response handshake and timeout detection. A response taken in the same
  // cycle the counter saturates is a normal accept, not a timeout.
  always_comb begin
    rsp_rdy       = owner_q ? RSP1_RDY_IN : RSP0_RDY_IN;
    timer_max     = &timer_q;
    RSP0_VLD_OUT  = (state_q == RESP) && !owner_q;
    RSP1_VLD_OUT  = (state_q == RESP) && owner_q;
    RSP0_DATA_OUT = rsp_data_q;
    RSP1_DATA_OUT = rsp_data_q;
    TIMEOUT_OUT   = (state_q == RESP) && !rsp_rdy && timer_max;
  end

  // The bank sees the latched request continuously; only the strobe is
  // qualified by the ISSUE state.
  always_comb begin
    BANK_WRITE_OUT      = (state_q == ISSUE) && write_q;
    BANK_ADDR_OUT       = addr_q;
    BANK_WRITE_DATA_OUT = data_q;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    write_d    = write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    timer_d    = timer_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          last_d  = grant;
          owner_d = grant;
          write_d = grant ? REQ1_WRITE_IN : REQ0_WRITE_IN;
          addr_d  = grant ? REQ1_ADDR_IN  : REQ0_ADDR_IN;
          data_d  = grant ? REQ1_DATA_IN  : REQ0_DATA_IN;
        end
      end
      ISSUE: begin
        // Bank read data is combinational, so for a write this is the value
        // present before the strobe lands.
        rsp_data_d = BANK_READ_DATA_IN;
        timer_d    = '0;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_rdy || timer_max) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TIMEOUT_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      timer_q    <= timer_d;
    end
  end

endmodule

// File: tb/tb_spinnaker_fpgas_reg_arbiter.sv
// Testbench for spinnaker_fpgas_reg_arbiter. A small register bank model
// answers the DUT; expected responses are pushed to a scoreboard when a
// request is driven and popped when the DUT presents a response.
module tb_spinnaker_fpgas_reg_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  typedef struct {
    bit          owner;
    logic [31:0] data;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          req0_vld, req0_rdy, req0_write;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_vld, req1_rdy, req1_write;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          rsp0_vld, rsp0_rdy;
  logic [DW-1:0] rsp0_data;
  logic          rsp1_vld, rsp1_rdy;
  logic [DW-1:0] rsp1_data;
  logic          bank_write;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata;
  logic [DW-1:0] bank_rdata;
  logic          timeout;

  logic [DW-1:0] bank_mem  [16];
  logic [DW-1:0] model_mem [16];
  exp_t          sb [$];
  int            errors = 0;
  int            checks = 0;

  spinnaker_fpgas_reg_arbiter #(
    .REGA_BITS(AW), .REGD_BITS(DW), .TIMEOUT_BITS(8)
  ) dut (
    .CLK_IN(clk), .RESET_N_IN(rst_n),
    .REQ0_VLD_IN(req0_vld), .REQ0_RDY_OUT(req0_rdy), .REQ0_WRITE_IN(req0_write),
    .REQ0_ADDR_IN(req0_addr), .REQ0_DATA_IN(req0_data),
    .REQ1_VLD_IN(req1_vld), .REQ1_RDY_OUT(req1_rdy), .REQ1_WRITE_IN(req1_write),
    .REQ1_ADDR_IN(req1_addr), .REQ1_DATA_IN(req1_data),
    .RSP0_VLD_OUT(rsp0_vld), .RSP0_RDY_IN(rsp0_rdy), .RSP0_DATA_OUT(rsp0_data),
    .RSP1_VLD_OUT(rsp1_vld), .RSP1_RDY_IN(rsp1_rdy), .RSP1_DATA_OUT(rsp1_data),
    .BANK_WRITE_OUT(bank_write), .BANK_ADDR_OUT(bank_addr),
    .BANK_WRITE_DATA_OUT(bank_wdata), .BANK_READ_DATA_IN(bank_rdata),
    .TIMEOUT_OUT(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register bank: combinational read, write on the strobe.
  assign bank_rdata = bank_mem[bank_addr[3:0]];
  always @(posedge clk) begin
    if (bank_write) bank_mem[bank_addr[3:0]] <= bank_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Pop one scoreboard entry and compare it with the response on display.
  task automatic checkResponse(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s observed=response expected=empty scoreboard", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_vld0"}, 32'(rsp0_vld), 32'(!e.owner));
      checkOutput({tag, "_vld1"}, 32'(rsp1_vld), 32'(e.owner));
      checkOutput({tag, "_data0"}, rsp0_data, e.data);
      checkOutput({tag, "_data1"}, rsp1_data, e.data);
    end
  endtask

  // Drive one request at a negedge and follow it through ISSUE and RESP,
  // taking the response on the first RESP cycle.
  task automatic applyStimulus(input bit req, input bit wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input string tag);
    if (req) begin
      req1_vld = 1'b1; req1_write = wr; req1_addr = addr; req1_data = data;
    end else begin
      req0_vld = 1'b1; req0_write = wr; req0_addr = addr; req0_data = data;
    end
    #1;
    checkOutput({tag, "_rdy0"}, 32'(req0_rdy), 32'(!req));
    checkOutput({tag, "_rdy1"}, 32'(req1_rdy), 32'(req));
    sb.push_back('{owner: req, data: model_mem[addr[3:0]]});
    if (wr) model_mem[addr[3:0]] = data;
    @(negedge clk);
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    checkOutput({tag, "_strobe"}, 32'(bank_write), 32'(wr));
    checkOutput({tag, "_addr"}, 32'(bank_addr), 32'(addr));
    if (wr) checkOutput({tag, "_wdata"}, bank_wdata, data);
    @(negedge clk);
    checkOutput({tag, "_strobe_off"}, 32'(bank_write), 32'd0);
    checkResponse(tag);
    if (req) rsp1_rdy = 1'b1; else rsp0_rdy = 1'b1;
    @(negedge clk);
    rsp0_rdy = 1'b0;
    rsp1_rdy = 1'b0;
    checkOutput({tag, "_done"}, 32'(rsp0_vld | rsp1_vld), 32'd0);
  endtask

  initial begin
    bit stop_after;
    int grants;
    int resp_cycles;
    bit order [4];
    order = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) begin
      bank_mem[i]  = 32'h1000_0000 + i;
      model_mem[i] = 32'h1000_0000 + i;
    end
    bank_mem[2]  = 32'hFFFF_FFFF;
    model_mem[2] = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    req0_vld = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_data = '0;
    req1_vld = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_data = '0;
    rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;

    // Reset state, including no RDY while held in reset.
    @(negedge clk);
    req0_vld = 1'b1;
    #1;
    checkOutput("reset_rdy0", 32'(req0_rdy), 32'd0);
    checkOutput("reset_vld", 32'(rsp0_vld | rsp1_vld), 32'd0);
    checkOutput("reset_strobe", 32'(bank_write), 32'd0);
    checkOutput("reset_timeout", 32'(timeout), 32'd0);
    checkOutput("reset_addr", 32'(bank_addr), 32'd0);
    checkOutput("reset_rspdata", rsp0_data, 32'd0);
    req0_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reads and writes from each requester.
    applyStimulus(1'b0, 1'b0, 14'h0002, 32'h0, "rd0_a2");
    applyStimulus(1'b1, 1'b1, 14'h0005, 32'h0000_000F, "wr1_a5");
    applyStimulus(1'b0, 1'b0, 14'h0005, 32'h0, "rd0_a5");

    // Response never taken: 255 waiting RESP cycles, then a timeout pulse.
    req0_vld = 1'b1; req0_write = 1'b0; req0_addr = 14'h0003;
    sb.push_back('{owner: 1'b0, data: model_mem[3]});
    @(negedge clk);
    req0_vld = 1'b0;
    @(negedge clk);
    checkResponse("to_resp");
    resp_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (timeout) break;
      if (rsp0_vld) resp_cycles++;
      @(negedge clk);
    end
    checkOutput("to_cycles", 32'(resp_cycles), 32'd255);
    checkOutput("to_pulse", 32'(timeout), 32'd1);
    @(negedge clk);
    checkOutput("to_idle_vld", 32'(rsp0_vld), 32'd0);
    checkOutput("to_pulse_end", 32'(timeout), 32'd0);

    // Response taken in the cycle the counter saturates: normal accept.
    req0_vld = 1'b1; req0_addr = 14'h0002;
    sb.push_back('{owner: 1'b0, data: model_mem[2]});
    @(negedge clk);
    req0_vld = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 255; i++) @(negedge clk);
    rsp0_rdy = 1'b1;
    #1;
    checkOutput("late_no_timeout", 32'(timeout), 32'd0);
    checkResponse("late_resp");
    @(negedge clk);
    rsp0_rdy = 1'b0;
    checkOutput("late_done", 32'(rsp0_vld), 32'd0);
    checkOutput("late_no_pulse", 32'(timeout), 32'd0);

    // Reset in the ISSUE cycle of a write abandons it.
    req1_vld = 1'b1; req1_write = 1'b1; req1_addr = 14'h0007; req1_data = 32'h0000_ABCD;
    @(negedge clk);
    req1_vld = 1'b0;
    checkOutput("rst_mid_strobe", 32'(bank_write), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_strobe_drop", 32'(bank_write), 32'd0);
    checkOutput("rst_mid_vld", 32'(rsp0_vld | rsp1_vld), 32'd0);
    @(negedge clk);
    checkOutput("rst_mid_vld_hold", 32'(rsp0_vld | rsp1_vld), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_no_resp", 32'(rsp0_vld | rsp1_vld), 32'd0);

    // Contention after reset: grant order 0,1,0,1, never both RDY.
    req0_vld = 1'b1; req0_write = 1'b0; req0_addr = 14'h0002;
    req1_vld = 1'b1; req1_write = 1'b0; req1_addr = 14'h0005;
    rsp0_rdy = 1'b1; rsp1_rdy = 1'b1;
    grants = 0;
    stop_after = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (stop_after) begin
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        stop_after = 1'b0;
      end
      #1;
      if (req0_rdy || req1_rdy) begin
        checkOutput("rr_not_both", 32'(req0_rdy & req1_rdy), 32'd0);
        if (grants < 4) begin
          checkOutput("rr_order", 32'(req1_rdy), 32'(order[grants]));
        end
        sb.push_back('{owner: req1_rdy, data: model_mem[req1_rdy ? 5 : 2]});
        grants++;
        if (grants == 4) stop_after = 1'b1;
      end
      if (rsp0_vld || rsp1_vld) checkResponse("rr_resp");
      @(negedge clk);
    end
    rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;
    checkOutput("rr_grants", 32'(grants), 32'd4);
    checkOutput("rr_sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
